// File: rtl/fc_layer_sched.sv
// fc_layer_sched: batch issue and result sequencer for the
// 16-lane dot-product engine in FC and LSTM-gate layers.
module fc_layer_sched #(
  parameter int DW              = 16,
  parameter int AW              = 12,
  parameter int CW              = 8,
  parameter int GUARD           = 4,
  parameter int BIAS_FIFO_DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] cfg_in_batches,
  input  logic [CW-1:0] cfg_out_neurons,
  input  logic          cfg_relu,
  input  logic          cfg_extend,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] feat_rd_addr,
  output logic [AW-1:0] weight_rd_addr,
  output logic          bias_rd_en,
  output logic [CW-1:0] bias_rd_addr,
  input  logic [DW-1:0] bias_rdata,
  output logic          cal_en,
  output logic          cal_extend_en,
  input  logic          cal_valid,
  input  logic [DW-1:0] cal_sum,
  output logic          res_we,
  output logic [CW-1:0] res_addr,
  output logic [DW-1:0] res_data
);

  localparam int AccW = DW + GUARD;
  localparam int SumW = AccW + 1;
  localparam int PW   = $clog2(BIAS_FIFO_DEPTH);
  localparam int PCW  = 2 * CW + 1;

  localparam logic signed [SumW-1:0] SMAX =
    {{(SumW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SumW-1:0] SMIN =
    {{(SumW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0] r_k;
  logic [CW-1:0] r_n;
  logic          r_relu;
  logic          r_extend;
  logic [CW-1:0] r_b;
  logic [CW-1:0] r_ni;
  logic [AW-1:0] r_waddr;
  logic          r_cal_en;
  logic          r_bias_push;
  logic [PCW-1:0] r_pend;
  logic [CW-1:0] r_rb;
  logic [CW-1:0] r_rn;
  logic signed [AccW-1:0] r_acc;
  logic [PW:0]   r_wptr;
  logic [PW:0]   r_rptr;
  logic [DW-1:0] r_bmem [BIAS_FIFO_DEPTH];
  logic          r_res_we;
  logic [CW-1:0] r_res_addr;
  logic [DW-1:0] r_res_data;
  logic          r_done;

  logic w_start;
  logic w_zero;
  logic w_issue;
  logic w_last_b;
  logic w_last_issue;
  logic w_acc;
  logic w_nb_done;
  logic w_last_fire;
  logic w_empty;
  logic signed [AccW-1:0] w_sext_sum;
  logic signed [AccW-1:0] w_acc_base;
  logic signed [AccW-1:0] w_acc_next;
  logic [DW-1:0] w_bias;
  logic signed [SumW-1:0] w_sum;
  logic [DW-1:0] w_sat;
  logic [DW-1:0] w_res;

  assign w_start  = (r_state == S_IDLE) && start;
  assign w_zero   = (cfg_in_batches == '0) ||
                    (cfg_out_neurons == '0);
  assign w_issue  = (r_state == S_ISSUE);
  assign w_last_b = (r_b == r_k - 1'b1);
  assign w_last_issue = w_issue && w_last_b &&
                        (r_ni == r_n - 1'b1);

  // Only returns that match an outstanding issue are counted.
  assign w_acc = cal_valid && busy && (r_pend != '0);
  assign w_nb_done = w_acc && (r_rb == r_k - 1'b1);
  assign w_last_fire = w_nb_done && (r_rn == r_n - 1'b1);

  assign busy = w_issue || (r_state == S_DRAIN);
  assign done = r_done;
  assign rd_en = w_issue;
  assign feat_rd_addr = w_issue ? AW'(r_b) : '0;
  assign weight_rd_addr = w_issue ? r_waddr : '0;
  assign bias_rd_en = w_issue && (r_b == '0);
  assign bias_rd_addr = w_issue ? r_ni : '0;
  assign cal_en = r_cal_en;
  assign cal_extend_en = r_extend;
  assign res_we = r_res_we;
  assign res_addr = r_res_addr;
  assign res_data = r_res_data;

  assign w_empty = (r_wptr == r_rptr);
  assign w_bias = r_bmem[r_rptr[PW-1:0]];

  assign w_sext_sum = {{GUARD{cal_sum[DW-1]}}, cal_sum};
  assign w_acc_base = (r_rb == '0) ? '0 : r_acc;
  assign w_acc_next = w_acc_base + w_sext_sum;
  assign w_sum = {w_acc_next[AccW-1], w_acc_next} +
                 {{(SumW-DW){w_bias[DW-1]}}, w_bias};

  // Saturate neuron total to DW, then optional ReLU.
  always_comb begin
    w_sat = w_sum[DW-1:0];
    if (w_sum > SMAX) begin
      w_sat = {1'b0, {(DW-1){1'b1}}};
    end else if (w_sum < SMIN) begin
      w_sat = {1'b1, {(DW-1){1'b0}}};
    end
    w_res = (r_relu && w_sat[DW-1]) ? '0 : w_sat;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = w_zero ? S_FINISH : S_ISSUE;
      end
      S_ISSUE: begin
        if (w_last_issue) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_last_fire || (r_rn == r_n)) w_next = S_FINISH;
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Config latch and issue-side batch/neuron/address counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k      <= '0;
      r_n      <= '0;
      r_relu   <= 1'b0;
      r_extend <= 1'b0;
      r_b      <= '0;
      r_ni     <= '0;
      r_waddr  <= '0;
    end else if (w_start) begin
      r_k      <= cfg_in_batches;
      r_n      <= cfg_out_neurons;
      r_relu   <= cfg_relu;
      r_extend <= cfg_extend;
      r_b      <= '0;
      r_ni     <= '0;
      r_waddr  <= '0;
    end else if (w_issue) begin
      r_waddr <= r_waddr + 1'b1;
      if (w_last_b) begin
        r_b  <= '0;
        r_ni <= r_ni + 1'b1;
      end else begin
        r_b <= r_b + 1'b1;
      end
    end
  end

  // BRAM-latency delays and the outstanding-batch count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cal_en    <= 1'b0;
      r_bias_push <= 1'b0;
      r_pend      <= '0;
    end else begin
      r_cal_en    <= rd_en;
      r_bias_push <= bias_rd_en;
      if (w_start) begin
        r_pend <= '0;
      end else begin
        r_pend <= r_pend + {{(PCW-1){1'b0}}, w_issue}
                         - {{(PCW-1){1'b0}}, w_acc};
      end
    end
  end

  // Bias FIFO pointers: push on returning bias, pop per neuron.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (w_start) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (r_bias_push) r_wptr <= r_wptr + 1'b1;
      if (w_nb_done)   r_rptr <= r_rptr + 1'b1;
    end
  end

  // Bias FIFO storage.
  always_ff @(posedge clk) begin
    if (r_bias_push) r_bmem[r_wptr[PW-1:0]] <= bias_rdata;
  end

  // Return-side counters and the channel-sum accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rb  <= '0;
      r_rn  <= '0;
      r_acc <= '0;
    end else if (w_start) begin
      r_rb  <= '0;
      r_rn  <= '0;
      r_acc <= '0;
    end else if (w_acc) begin
      r_acc <= w_acc_next;
      if (w_nb_done) begin
        r_rb <= '0;
        r_rn <= r_rn + 1'b1;
      end else begin
        r_rb <= r_rb + 1'b1;
      end
    end
  end

  // Result write port and end-of-layer pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_we   <= 1'b0;
      r_res_addr <= '0;
      r_res_data <= '0;
      r_done     <= 1'b0;
    end else begin
      r_res_we <= w_nb_done;
      r_done   <= (r_state == S_FINISH);
      if (w_nb_done) begin
        r_res_addr <= r_rn;
        r_res_data <= w_res;
      end
    end
  end

  a_no_empty_pop: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(w_nb_done && w_empty)
  );

endmodule
